// File: rtl/t07_spi_tft_tx.sv
// SPI mode-0 transmitter for the TFT MMIO path: 1-4 byte frames, MSB first, with D/C level.
// Define T07_TFT_TX_FIFO_EN for a 4-deep request queue (the active frame holds one slot).
module t07_spi_tft_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wi,
  input  logic [31:0] data_in,
  input  logic [31:0] addr_in,
  output logic        ack,
  output logic        done,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic        dc
);
  localparam int DIV = (CLK_DIV < 1) ? 1 : CLK_DIV;
  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    bits_q, bits_d;
  logic [31:0]   sr_q, sr_d;
  logic [1:0]    n_q, n_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          cs_n_q, cs_n_d;
  logic          dc_q, dc_d;
  logic          ack_q, ack_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic        tick, active, hold_exit, can_start;
  logic        full, accept, start, q_nonempty;
  logic [31:0] src_data;
  logic [1:0]  src_n;
  logic        src_dc;
  logic [5:0]  total_bits;
  logic        unused_addr;

  assign unused_addr = ^addr_in[31:3];
  assign tick = (cnt_q == CNT_LAST);
  assign active = (state_q != IDLE);
  assign hold_exit = (state_q == HOLD) && tick;
  assign can_start = (state_q == IDLE) || hold_exit;
  assign accept = wi && !full;
  assign total_bits = {1'b0, n_q, 3'b000} + 6'd8;

`ifdef T07_TFT_TX_FIFO_EN
  logic [31:0] f_data [4];
  logic [1:0]  f_n [4];
  logic        f_dc [4];
  logic [1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic [3:0]  occ;
  logic        have_head, push, pop;

  assign occ = {1'b0, fcnt_q} + {3'b000, active};
  assign full = (occ >= 4'd4);
  assign have_head = (fcnt_q != 3'd0);
  assign start = can_start && (have_head || accept);
  assign pop = start && have_head;
  // An idle request with an empty queue bypasses it entirely.
  assign push = accept && !(start && !have_head);
  assign src_data = have_head ? f_data[rd_q] : data_in;
  assign src_n = have_head ? f_n[rd_q] : addr_in[1:0];
  assign src_dc = have_head ? f_dc[rd_q] : addr_in[2];

  always_ff @(posedge clk) begin
    if (push) begin
      f_data[wr_q] <= data_in;
      f_n[wr_q] <= addr_in[1:0];
      f_dc[wr_q] <= addr_in[2];
    end
  end
`else
  assign full = active && !hold_exit;
  assign start = can_start && accept;
  assign src_data = data_in;
  assign src_n = addr_in[1:0];
  assign src_dc = addr_in[2];
`endif

  function automatic logic [31:0] align(input logic [31:0] d,
                                        input logic [1:0] n);
    logic [31:0] r;
    unique case (n)
      2'd0: r = {d[7:0], 24'h0};
      2'd1: r = {d[15:0], 16'h0};
      2'd2: r = {d[23:0], 8'h0};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bits_d = bits_q;
    sr_d = sr_q;
    n_d = n_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    cs_n_d = cs_n_q;
    dc_d = dc_q;
    ack_d = accept;
    done_d = 1'b0;
    q_nonempty = 1'b0;
`ifdef T07_TFT_TX_FIFO_EN
    wr_d = wr_q + {1'b0, push};
    rd_d = rd_q + {1'b0, pop};
    fcnt_d = fcnt_q + {2'b00, push} - {2'b00, pop};
    q_nonempty = (fcnt_d != 3'd0);
`endif
    unique case (state_q)
      IDLE: ;
      SETUP: begin
        if (tick) begin
          state_d = SHIFT;
          cnt_d = '0;
          sclk_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (!tick) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (sclk_q) begin
            // Falling edge: next bit goes out a full half-period early.
            sclk_d = 1'b0;
            sr_d = {sr_q[30:0], 1'b0};
            mosi_d = sr_q[30];
            bits_d = bits_q + 6'd1;
          end else if (bits_q == total_bits) begin
            state_d = HOLD;
            cs_n_d = 1'b1;
            mosi_d = 1'b0;
          end else begin
            sclk_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = IDLE;
          cnt_d = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = SETUP;
      cnt_d = '0;
      bits_d = '0;
      n_d = src_n;
      dc_d = src_dc;
      sr_d = align(src_data, src_n);
      mosi_d = sr_d[31];
      cs_n_d = 1'b0;
      sclk_d = 1'b0;
    end
    busy_d = (state_d != IDLE) || done_d || q_nonempty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bits_q <= '0;
      sr_q <= '0;
      n_q <= '0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      cs_n_q <= 1'b1;
      dc_q <= 1'b0;
      ack_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef T07_TFT_TX_FIFO_EN
      wr_q <= '0;
      rd_q <= '0;
      fcnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bits_q <= bits_d;
      sr_q <= sr_d;
      n_q <= n_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      cs_n_q <= cs_n_d;
      dc_q <= dc_d;
      ack_q <= ack_d;
      done_q <= done_d;
      busy_q <= busy_d;
`ifdef T07_TFT_TX_FIFO_EN
      wr_q <= wr_d;
      rd_q <= rd_d;
      fcnt_q <= fcnt_d;
`endif
    end
  end

  assign ack = ack_q;
  assign done = done_q;
  assign busy = busy_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign cs_n = cs_n_q;
  assign dc = dc_q;
endmodule

// File: tb/tb_t07_spi_tft_tx.sv
// Scoreboard bench for t07_spi_tft_tx: frames decoded off the SPI pins are checked
// against an expected-frame queue; a second instance covers CLK_DIV=0.
module tb_t07_spi_tft_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wi = 1'b0;
  logic wi_b = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] addr_in = '0;
  logic ack, done, busy, sclk, mosi, cs_n, dc;
  logic ack_b, done_b, busy_b, sclk_b, mosi_b, cs_n_b, dc_b;

  always #5 clk = ~clk;

  t07_spi_tft_tx #(.CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .wi(wi), .data_in(data_in), .addr_in(addr_in),
    .ack(ack), .done(done), .busy(busy), .sclk(sclk), .mosi(mosi),
    .cs_n(cs_n), .dc(dc)
  );

  t07_spi_tft_tx #(.CLK_DIV(0)) dut_b (
    .clk(clk), .rst(rst), .wi(wi_b), .data_in(data_in), .addr_in(addr_in),
    .ack(ack_b), .done(done_b), .busy(busy_b), .sclk(sclk_b), .mosi(mosi_b),
    .cs_n(cs_n_b), .dc(dc_b)
  );

  typedef struct {
    logic [31:0] d;
    int          nb;
    logic        dc;
  } frame_t;

  frame_t exp_q[$];
  int gap_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt = 0, done_cnt = 0;
  int last_ack_cyc = -1, last_done_cyc = -1;
  int start_cyc = -1, end_cyc = -1;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic void expect_frame(input logic [31:0] d, input int nb,
                                       input logic f_dc);
    frame_t f;
    f.d = d;
    f.nb = nb;
    f.dc = f_dc;
    exp_q.push_back(f);
  endfunction

  // Monitor: decode frames from the pins of the CLK_DIV=2 instance
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
  logic in_frame = 1'b0, fdc = 1'b0, dc_bad = 1'b0, mosi_bad = 1'b0;
  logic [31:0] cap = '0;
  int nb = 0, hi_len = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      hi_len = 0;
    end else begin
      if (ack) begin ack_cnt++; last_ack_cyc = cyc; end
      if (done) begin done_cnt++; last_done_cyc = cyc; end
      if (prev_cs && !cs_n) begin
        in_frame = 1'b1;
        cap = '0;
        nb = 0;
        fdc = dc;
        dc_bad = 1'b0;
        mosi_bad = 1'b0;
        start_cyc = cyc;
        gap_q.push_back(hi_len);
      end
      if (cs_n) hi_len++;
      else hi_len = 0;
      if (in_frame && !cs_n) begin
        if (!prev_sclk && sclk) begin
          cap = {cap[30:0], mosi};
          nb++;
        end
        if (dc !== fdc) dc_bad = 1'b1;
        if (!prev_cs && mosi !== prev_mosi && !(prev_sclk && !sclk))
          mosi_bad = 1'b1;
      end
      if (in_frame && !prev_cs && cs_n) begin
        in_frame = 1'b0;
        end_cyc = cyc - 1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame unexpected got data=%0h bits=%0d", cap, nb);
        end else begin
          frame_t e;
          e = exp_q.pop_front();
          if (cap !== e.d || nb != e.nb || fdc !== e.dc || dc_bad || mosi_bad) begin
            errors++;
            $display("FAIL frame got data=%0h bits=%0d dc=%0b dcchg=%0b mosichg=%0b exp data=%0h bits=%0d dc=%0b",
                     cap, nb, fdc, dc_bad, mosi_bad, e.d, e.nb, e.dc);
          end
        end
      end
    end
    prev_cs = cs_n;
    prev_sclk = sclk;
    prev_mosi = mosi;
  end

  task automatic send(input logic [31:0] d, input logic [31:0] a,
                      output int c);
    @(posedge clk);
    #1;
    data_in = d;
    addr_in = a;
    wi = 1'b1;
    c = cyc;
    @(posedge clk);
    #1;
    wi = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int max_cyc);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < max_cyc) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s timeout got=no_done exp=done within %0d", nm, max_cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int c0, a0, d0, gi;
    // reset state
    idle(3);
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_dc", dc, 0);
    chk("rst_cs_n_b", cs_n_b, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // one data byte, exact timing at CLK_DIV=2
    expect_frame(32'hA5, 8, 1'b1);
    send(32'h0000_00A5, 32'h4, c0);
    @(negedge clk);
    chk("busy_after_ack", busy, 1);
    wait_done("a5_done", 60);
    chk("a5_ack_cyc", last_ack_cyc, c0 + 1);
    chk("a5_cs_first", start_cyc, c0 + 1);
    chk("a5_cs_last", end_cyc, c0 + 34);
    chk("a5_done_cyc", last_done_cyc, c0 + 37);
    @(negedge clk);
    chk("a5_busy_clear", busy, 0);
    idle(3);

    // widths: 4, 2 and 3 bytes; upper address bits ignored
    expect_frame(32'hDEAD_BEEF, 32, 1'b0);
    send(32'hDEAD_BEEF, 32'h3, c0);
    wait_done("w32_done", 200);
    idle(2);
    expect_frame(32'h1234, 16, 1'b0);
    send(32'hFFFF_1234, 32'h1, c0);
    wait_done("w16_done", 120);
    idle(2);
    expect_frame(32'hAB_CDEF, 24, 1'b0);
    send(32'h11AB_CDEF, 32'hFA, c0);
    wait_done("w24_done", 160);
    idle(2);

`ifdef T07_TFT_TX_FIFO_EN
    // queued requests during a transfer
    gi = gap_q.size();
    a0 = ack_cnt;
    expect_frame(32'h3C, 8, 1'b1);
    send(32'h3C, 32'h4, c0);
    idle(8);
    expect_frame(32'h11, 8, 1'b1);
    expect_frame(32'h22, 8, 1'b1);
    expect_frame(32'h33, 8, 1'b1);
    @(posedge clk);
    #1;
    addr_in = 32'h4;
    wi = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      data_in = 32'(i * 32'h11);
      @(posedge clk);
      #1;
    end
    wi = 1'b0;
    idle(2);
    chk("fifo_acks", ack_cnt - a0, 4);
    @(negedge clk);
    chk("fifo_busy", busy, 1);
    for (int i = 0; i < 4; i++) wait_done("fifo_done", 60);
    checks++;
    if (gap_q.size() < gi + 4) begin
      errors++;
      $display("FAIL fifo_frames got=%0d exp=%0d", gap_q.size() - gi, 4);
    end else begin
      for (int i = 1; i < 4; i++) chk("fifo_gap", gap_q[gi + i], 2);
    end
    idle(2);
    @(negedge clk);
    chk("fifo_busy_clear", busy, 0);
`else
    // request while shifting is dropped
    a0 = ack_cnt;
    expect_frame(32'h3C, 8, 1'b1);
    send(32'h3C, 32'h4, c0);
    idle(12);
    @(posedge clk);
    #1;
    data_in = 32'h99;
    addr_in = 32'h4;
    wi = 1'b1;
    @(posedge clk);
    #1 wi = 1'b0;
    wait_done("drop_done", 60);
    idle(60);
    chk("drop_acks", ack_cnt - a0, 1);
`endif
    idle(3);

    // abort mid-shift; wi during reset is ignored
    a0 = ack_cnt;
    send(32'h5A, 32'h4, c0);
    idle(14);
    @(posedge clk);
    #1;
    rst = 1'b1;
    data_in = 32'h77;
    addr_in = 32'h4;
    wi = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wi = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    chk("abort_cs_n", cs_n, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ack", ack, 0);
    idle(60);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_acks", ack_cnt - a0, 1);
    expect_frame(32'h81, 8, 1'b0);
    send(32'h81, 32'h0, c0);
    wait_done("post_abort_done", 60);
    idle(3);

    // CLK_DIV=0 behaves as CLK_DIV=1
    begin
      int ack_c = -1, first = -1, last = -1, done_c = -1;
      int rises = 0, last_rise = -1, bad_gap = 0;
      logic ps = 1'b0;
      logic [7:0] bcap = '0;
      @(posedge clk);
      #1;
      data_in = 32'hC3;
      addr_in = 32'h4;
      wi_b = 1'b1;
      c0 = cyc;
      @(posedge clk);
      #1 wi_b = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (ack_b) ack_c = cyc;
        if (!cs_n_b) begin
          if (first < 0) first = cyc;
          last = cyc;
        end
        if (sclk_b && !ps) begin
          rises++;
          bcap = {bcap[6:0], mosi_b};
          if (last_rise >= 0 && cyc - last_rise != 2) bad_gap++;
          last_rise = cyc;
        end
        if (done_b) done_c = cyc;
        ps = sclk_b;
      end
      chk("div0_ack_cyc", ack_c, c0 + 1);
      chk("div0_cs_first", first, c0 + 1);
      chk("div0_cs_last", last, c0 + 17);
      chk("div0_done_cyc", done_c, c0 + 19);
      chk("div0_rises", rises, 8);
      chk("div0_data", {24'h0, bcap}, 32'hC3);
      chk("div0_period", bad_gap, 0);
    end

    chk("exp_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/t07_spi_tft_tx.md
T07_SPI_TFT_TX -- requirements
Module: t07_spi_tft_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles; value 0 is treated as 1.
REQ-002 SHALL have port clk  input  1: single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-004 SHALL have port wi  input  1: write-initiate request from the MMIO TFT path, sampled each edge.
REQ-005 SHALL have port data_in  input  32: payload; the low 8*N bits are sent, MSB first.
REQ-006 SHALL have port addr_in  input  32: bits[1:0] give byte count N = value+1; bit[2] gives the D/C level (0 = command, 1 = data); other bits are ignored.
REQ-007 SHALL have port ack  output  1: one-cycle pulse when a request is accepted.
REQ-008 SHALL have port done  output  1: one-cycle pulse when a transfer completes.
REQ-009 SHALL have port busy  output  1: high while any transfer is active or pending.
REQ-010 SHALL have ports sclk, mosi, cs_n, dc  output  1 each: SPI mode-0 master pins to the TFT.

Function
REQ-011 SHALL implement the states IDLE, SETUP, SHIFT and HOLD.
REQ-012 SHALL, in IDLE with a request available, latch data, N and dc at edge k and enter SETUP at cycle k+1, driving cs_n=0, dc=latched value and mosi=bit 8N-1.
REQ-013 SHALL hold SETUP for CLK_DIV cycles with sclk=0, then enter SHIFT.
REQ-014 SHALL, in SHIFT, toggle sclk every CLK_DIV cycles for 2*8N half-periods (rising edge first); mosi changes only on falling edges and is stable for a full half-period before each rising edge.
REQ-015 SHALL, after the final falling edge, enter HOLD with cs_n=1, sclk=0, mosi=0 for CLK_DIV cycles.
REQ-016 SHALL, on HOLD exit, pulse done for one cycle and return to IDLE, or go directly to SETUP if another request is pending.
REQ-017 SHALL use a 6-bit bit counter and a 32-bit shift register, with no wrap beyond 8N bits; when N<4, bits above 8N-1 are never driven.
REQ-018 SHALL hold dc constant from SETUP through HOLD; dc SHALL change only when a new transfer is latched.
REQ-019 SHALL assert busy from the cycle after acceptance until the done cycle inclusive, and also whenever the FIFO is non-empty.
REQ-020 SHALL, on simultaneous done and a new wi, produce ack and done in the same cycle.

Reset
REQ-021 SHALL, with rst high at an edge, force state IDLE, sclk=0, mosi=0, cs_n=1, dc=0, ack=0, done=0, busy=0, clear the counters and flush the FIFO.
REQ-022 SHALL treat rst mid-transfer as an abort: cs_n goes high at that edge, no done pulse is issued, and the partial frame is discarded.
REQ-023 SHALL ignore wi in any cycle where rst is high.

Configuration
REQ-024 SHALL use the macro T07_TFT_TX_FIFO_EN to select request buffering.
REQ-025 SHALL, with T07_TFT_TX_FIFO_EN defined, include a 4-entry request FIFO (data, N, dc):
- wi is accepted with an ack whenever the FIFO is not full, including during a transfer;
- wi while full gets no ack and is dropped;
- entries are sent in order.
REQ-026 SHALL, without T07_TFT_TX_FIFO_EN, accept wi only in IDLE (ack pulse); wi while busy gets no ack and is dropped.

Verification
REQ-027 SHALL cover: CLK_DIV=2, wi at cycle 0 with data_in=0x000000A5, addr_in=0x4 -> ack at cycle 1, cs_n low during cycles 1-34, 8 sclk rises carrying bits 1,0,1,0,0,1,0,1, dc=1, done at cycle 37.
REQ-028 SHALL cover: addr_in=0x3, data_in=0xDEADBEEF -> 32 bits DEADBEEF sent MSB first, dc=0, exactly 32 sclk rises.
REQ-029 SHALL cover: FIFO build, four back-to-back wi during a transfer -> 3 acks then 1 drop (FIFO full); all accepted frames sent in order with a HOLD gap of CLK_DIV cycles between them.
REQ-030 SHALL cover: non-FIFO build, wi during SHIFT -> no ack, frame not sent, and the active frame is unaffected.
REQ-031 SHALL cover: rst asserted mid-SHIFT -> next cycle cs_n=1, sclk=0, busy=0, no done pulse; a fresh wi afterwards is sent correctly.
REQ-032 SHALL cover: CLK_DIV=0 -> timing identical to CLK_DIV=1 (one SCLK period every 2 cycles).
